// File: rtl/one_to_n_distributor.sv
// one_to_n_distributor
//   Steers a single flit stream into N single-flit output slots. Head and
//   single flits pick their slot from the destination field. Body and tail
//   flits follow the slot locked by the head until the tail. Malformed,
//   orphan or unroutable flits are swallowed and counted.
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   in_i          incoming flit, type in top HEADER_LEN bits, destination below it
//   in_valid_i    incoming flit valid
//   in_avail_o    flit can be taken this cycle (combinational on out_avail_i)
//   out_o         N output slots, slot i = out_o[FLIT_SIZE*i +: FLIT_SIZE]
//   out_valid_o   slot i holds a flit
//   out_avail_i   downstream i consumes slot i this cycle
//   err_o         one-cycle pulse after each dropped flit
//   err_cnt_o     saturating dropped-flit count
module one_to_n_distributor #(
    parameter int unsigned           N           = 8,
    parameter int unsigned           FLIT_SIZE   = 64,
    parameter int unsigned           HEADER_LEN  = 2,
    parameter logic [HEADER_LEN-1:0] HEAD_FLIT   = HEADER_LEN'(2'b01),
    parameter logic [HEADER_LEN-1:0] BODY_FLIT   = HEADER_LEN'(2'b10),
    parameter logic [HEADER_LEN-1:0] TAIL_FLIT   = HEADER_LEN'(2'b11),
    parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = HEADER_LEN'(2'b00)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_SIZE-1:0]   in_i,
    input  logic                   in_valid_i,
    output logic                   in_avail_o,
    output logic [FLIT_SIZE*N-1:0] out_o,
    output logic [N-1:0]           out_valid_o,
    input  logic [N-1:0]           out_avail_i,
    output logic                   err_o,
    output logic [15:0]            err_cnt_o
);

    localparam int unsigned DEST_W    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DEST_SPAN = 1 << DEST_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DEST_W-1:0]       lock_q, lock_d;
    logic [FLIT_SIZE-1:0]    slot_q [N];
    logic [N-1:0]            out_valid_q, out_valid_d;
    logic                    err_q, err_d;
    logic [15:0]             err_cnt_q, err_cnt_d;

    logic [HEADER_LEN-1:0]   flit_type;
    logic [DEST_W-1:0]       dest;
    logic [DEST_W-1:0]       tgt;
    logic [DEST_SPAN-1:0]    dest_ok_vec;
    logic [DEST_SPAN-1:0]    free_pad;
    logic [DEST_SPAN-1:0]    wr_mask;
    logic [N-1:0]            drain;
    logic                    avail;
    logic                    wr_en;
    logic                    drop;

    assign flit_type = in_i[FLIT_SIZE-1 -: HEADER_LEN];
    assign dest      = in_i[FLIT_SIZE-HEADER_LEN-1 -: DEST_W];
    assign drain     = out_valid_q & out_avail_i;

    // Slot free map, padded to the full destination code space so any dest indexes it.
    assign free_pad  = DEST_SPAN'(~out_valid_q | out_avail_i);

    // Destination codes at or above N are unroutable.
    for (genvar g = 0; g < DEST_SPAN; g++) begin : g_dest_ok
        assign dest_ok_vec[g] = (g < N);
    end

    // Next-state, steering and drop decision.
    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        tgt         = lock_q;
        avail       = 1'b0;
        wr_en       = 1'b0;
        drop        = 1'b0;
        wr_mask     = '0;
        out_valid_d = out_valid_q & ~drain;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                tgt = dest;
                if ((flit_type == SINGLE_FLIT || flit_type == HEAD_FLIT) && dest_ok_vec[dest]) begin
                    avail = free_pad[dest];
                    if (in_valid_i && avail) begin
                        wr_en = 1'b1;
                        if (flit_type == HEAD_FLIT) begin
                            lock_d  = dest;
                            state_d = ST_BUSY;
                        end
                    end
                end else begin
                    // Orphans and unroutable flits are always accepted and discarded.
                    avail = 1'b1;
                    if (in_valid_i) begin
                        drop = 1'b1;
                        if (flit_type == HEAD_FLIT) begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (flit_type == BODY_FLIT || flit_type == TAIL_FLIT) begin
                    avail = free_pad[lock_q];
                    if (in_valid_i && avail) begin
                        wr_en = 1'b1;
                        if (flit_type == TAIL_FLIT) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    // A new packet start inside a packet is discarded; the lock is kept.
                    avail = 1'b1;
                    drop  = in_valid_i;
                end
            end
            ST_DROP: begin
                avail = 1'b1;
                drop  = in_valid_i;
                if (in_valid_i && flit_type == TAIL_FLIT) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_en) begin
            wr_mask = DEST_SPAN'(1) << tgt;
        end
        out_valid_d = out_valid_d | wr_mask[N-1:0];
        err_d       = drop;
        if (drop && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // State, slot and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lock_q      <= '0;
            out_valid_q <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            for (int i = 0; i < N; i++) begin
                if (wr_mask[i]) begin
                    slot_q[i] <= in_i;
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign out_o[FLIT_SIZE*g +: FLIT_SIZE] = slot_q[g];
    end

    assign out_valid_o = out_valid_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;
    assign in_avail_o  = avail & ~rst;

endmodule
